pixel_row_scheduler: RTL
========================

Name: pixel_row_scheduler

Overview:
- Clocked sequencer feeding the per-filter-row pixel memory PEs of the 3x3 conv array.
- Fetches ifmap rows (ROW_LEN packed pixels) from the input SRAM and broadcasts each row to exactly the PEs that consume it: input row i goes to PE k iff 0 <= i-k <= FILT_H-1.
- Repeats the row sweep for NUM_TS timesteps per start command, then reports done.

Parameters:
- DWIDTH, 8, bits per pixel
- ROW_LEN, 5, pixels per row (row bus width = DWIDTH*ROW_LEN)
- NUM_ROWS, 5, ifmap rows per timestep
- FILT_H, 3, filter height; also the number of PEs driven (PE k = filter row k)
- NUM_TS, 10, timesteps per start
- ADDR_W, 8, memory address width; must satisfy NUM_TS*NUM_ROWS <= 2**ADDR_W

Ports:
- clk, input, 1, single clock, all logic posedge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, one-cycle request to begin a job; sampled only in IDLE
- busy, output, 1, high from the cycle after an accepted start until done
- done, output, 1, one-cycle pulse after the last handshake of the last timestep
- mem_rd_en, output, 1, read strobe; data is returned exactly 1 cycle later
- mem_rd_addr, output, ADDR_W, ts*NUM_ROWS + row
- mem_rd_data, input, DWIDTH*ROW_LEN, row returned by memory
- pe_data, output, DWIDTH*ROW_LEN, broadcast row register shared by all PEs
- pe_row_idx, output, $clog2(NUM_ROWS), index of the row held in pe_data
- pe_valid, output, FILT_H, per-PE valid
- pe_ready, input, FILT_H, per-PE ready

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, pe_valid=0, pe_data=0, pe_row_idx=0, row=0, ts=0.
- FSM states: IDLE, FETCH, WAIT_MEM, DISPATCH, ADVANCE, DONE.
- IDLE: start=1 -> FETCH, busy=1. A start while busy is ignored (no queueing).
- FETCH: mem_rd_en=1 for exactly one cycle with addr = ts*NUM_ROWS+row -> WAIT_MEM.
- WAIT_MEM: latch mem_rd_data into pe_data and row into pe_row_idx; pe_valid <= target mask -> DISPATCH.
- Target mask: bit k = (row >= k) && (row - k <= FILT_H-1). With the defaults: row0 -> 001, row1 -> 011, row2 -> 111, row3 -> 110, row4 -> 100.
- DISPATCH: a handshake on PE k occurs on a cycle with pe_valid[k] && pe_ready[k], which clears pe_valid[k] on the next edge. Each PE is handled independently; ready on a non-targeted PE has no effect. pe_data is held stable while any valid bit is set. When all valid bits are clear (including when several handshakes complete in the same cycle) -> ADVANCE.
- Valid never drops before its handshake; ready may toggle freely.
- ADVANCE:
  - if row < NUM_ROWS-1: row++ -> FETCH
  - else if ts < NUM_TS-1: row=0, ts++ -> FETCH
  - else -> DONE
- DONE: done=1 for one cycle, busy=0, row=ts=0 -> IDLE. A start in the DONE cycle is ignored.
- Minimum row period is 4 cycles (FETCH, WAIT_MEM, DISPATCH with all ready, ADVANCE); a job with all readies held high takes NUM_TS*NUM_ROWS*4 + 1 cycles from start to done.
- Reset mid-job: everything returns to reset values immediately; the partial job is abandoned, and PEs must be reset alongside.

Optional Feature:
- Macro: PIXEL_SCHED_PERF_CNT_EN.
- When defined: adds output stall_cycles (32 bits). It counts DISPATCH cycles in which any pe_valid bit is set with no handshake on any PE. It clears on an accepted start, holds after done, and saturates at all-ones.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pixel_sched_pkg: state enum type, row_t typedef (logic [DWIDTH*ROW_LEN-1:0]), and a constant function target_mask(row) returning FILT_H bits.
- One natural sub-module: pe_valid_tracker (per-PE valid set/clear bank with all-clear output).

Test Plan:
- Reset then start, all pe_ready=1, NUM_TS=1 -> addresses 0..4 issued; masks 001,011,111,110,100; done pulses at cycle 21 after start.
- PE1 ready held low 10 cycles on row 2 -> pe_valid=010 held and pe_data stable; PE0/PE2 handshake early; FETCH of row 3 only after PE1 handshakes.
- Memory returns 0x0102030405 for addr 2 -> pe_data=0x0102030405 and pe_row_idx=2 on the cycle pe_valid rises.
- NUM_TS=2 -> second sweep addresses 5..9; exactly one done pulse, after row 4 of ts 1.
- start pulsed during busy and in the DONE cycle -> ignored; a start one cycle after DONE begins a new job at addr 0.
- rst_n asserted mid-DISPATCH of row 3 -> outputs zero asynchronously; after release a new start restarts at addr 0; with PIXEL_SCHED_PERF_CNT_EN, stall_cycles=10 after the PE1 stall scenario.

Source files
------------

// File: rtl/pixel_sched_pkg.sv
// Shared types and helpers for the pixel row scheduler.
// Holds the default geometry, the FSM state encoding, the row bus type and
// the filter-row target mask function.
package pixel_sched_pkg;

    localparam int DWIDTH_DEF   = 8;
    localparam int ROW_LEN_DEF  = 5;
    localparam int NUM_ROWS_DEF = 5;
    localparam int FILT_H_DEF   = 3;
    localparam int NUM_TS_DEF   = 10;
    localparam int ADDR_W_DEF   = 8;

    // Upper bound on PEs a mask can describe; callers size-cast down to FILT_H.
    localparam int MAX_PE = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_DISPATCH,
        S_ADVANCE,
        S_DONE
    } state_t;

    typedef logic [DWIDTH_DEF*ROW_LEN_DEF-1:0] row_t;

    // Input row 'row' feeds PE k when 0 <= row-k <= filt_h-1.
    function automatic logic [MAX_PE-1:0] target_mask(input int row, input int filt_h = FILT_H_DEF);
        logic [MAX_PE-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_PE; k++) begin
            if (k < filt_h && row >= k && (row - k) <= (filt_h - 1)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pixel_row_scheduler_pe_valid_tracker.sv
// Per-PE valid bank: loads a target mask, clears each bit on its own handshake.
// Latency: valid bits update on the edge after load / handshake.
// Backpressure: a bit stays set until its PE's ready is seen with it.
// Ports: load/load_mask set the bank; pe_ready clears handshaken bits;
//        pe_valid is the registered bank; all_clear_next is high when the
//        bank will be empty after this edge (no load pending).
module pe_valid_tracker #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_mask,
    input  logic [N-1:0] pe_ready,
    output logic [N-1:0] pe_valid,
    output logic         all_clear_next
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_valid <= '0;
        end else if (load) begin
            pe_valid <= load_mask;
        end else begin
            pe_valid <= pe_valid & ~pe_ready;
        end
    end

    // Bits that survive this edge: valid without a matching ready.
    assign all_clear_next = ~|(pe_valid & ~pe_ready);

endmodule

// File: rtl/pixel_row_scheduler.sv
// Row sequencer: fetches ifmap rows and broadcasts each to the PEs that use it.
// Latency: 4 cycles per row minimum (fetch, mem wait, dispatch, advance).
// Backpressure: next fetch waits until every targeted PE has handshaken.
// Ports: start/busy/done job control; mem_rd_en/mem_rd_addr/mem_rd_data
//        single-cycle-latency SRAM read; pe_data/pe_row_idx shared row
//        register; pe_valid/pe_ready per-PE handshake.
// Optional: PIXEL_SCHED_PERF_CNT_EN adds the stall_cycles counter output.
module pixel_row_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int ROW_LEN  = ROW_LEN_DEF,
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int FILT_H   = FILT_H_DEF,
    parameter int NUM_TS   = NUM_TS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_rd_addr,
    input  logic [DWIDTH*ROW_LEN-1:0]   mem_rd_data,
    output logic [DWIDTH*ROW_LEN-1:0]   pe_data,
    output logic [$clog2(NUM_ROWS)-1:0] pe_row_idx,
`ifdef PIXEL_SCHED_PERF_CNT_EN
    output logic [31:0]                 stall_cycles,
`endif
    output logic [FILT_H-1:0]           pe_valid,
    input  logic [FILT_H-1:0]           pe_ready
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int TW = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
    localparam logic [TW-1:0] TS_LAST  = TW'(NUM_TS - 1);

    state_t            state;
    logic [RW-1:0]     row_q;
    logic [TW-1:0]     ts_q;
    logic [FILT_H-1:0] tgt_mask;
    logic              all_clear_next;

    assign tgt_mask = FILT_H'(target_mask(int'(row_q), FILT_H));

    // The bank loads in the same edge that captures the returned row.
    pe_valid_tracker #(
        .N (FILT_H)
    ) u_valid_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (state == S_WAIT_MEM),
        .load_mask      (tgt_mask),
        .pe_ready       (pe_ready),
        .pe_valid       (pe_valid),
        .all_clear_next (all_clear_next)
    );

    // Rows are read in order, so the address is a running count equal to
    // ts*NUM_ROWS + row; it is bumped together with row/ts in ADVANCE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            pe_data     <= '0;
            pe_row_idx  <= '0;
            row_q       <= '0;
            ts_q        <= '0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    pe_data    <= mem_rd_data;
                    pe_row_idx <= row_q;
                    state      <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    if (all_clear_next) begin
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (row_q != ROW_LAST) begin
                        row_q       <= row_q + 1'b1;
                        mem_rd_addr <= mem_rd_addr + 1'b1;
                        mem_rd_en   <= 1'b1;
                        state       <= S_FETCH;
                    end else if (ts_q != TS_LAST) begin
                        row_q       <= '0;
                        ts_q        <= ts_q + 1'b1;
                        mem_rd_addr <= mem_rd_addr + 1'b1;
                        mem_rd_en   <= 1'b1;
                        state       <= S_FETCH;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    row_q       <= '0;
                    ts_q        <= '0;
                    mem_rd_addr <= '0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIXEL_SCHED_PERF_CNT_EN
    // A stall is a dispatch cycle where rows are pending but no PE takes one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == S_DISPATCH && (|pe_valid) && !(|(pe_valid & pe_ready))
                     && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
